// File: rtl/moore_bit_serializer.sv
// rtl/moore_bit_serializer.sv - parallel-to-serial front end feeding the Moore detector serial input
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every word.
module moore_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH);
  localparam logic [7:0]    GAP_N = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SER_PARITY_EN
    GAP   = 2'd2,
    PAR   = 2'd3
`else
    GAP   = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [7:0]       gap_cnt;
  logic             word_end;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // word_end marks the cycle whose bit is the final one of the word on `out`
  always_comb begin
`ifdef SER_PARITY_EN
    word_end = (state == PAR);
`else
    word_end = (state == SHIFT) && (cnt == LAST);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      din_ready <= 1'b0;
      out       <= IDLE_LEVEL;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (word_end) begin
        out       <= IDLE_LEVEL;
        out_valid <= 1'b0;
        cnt       <= '0;
        if (GAP_CYCLES > 0) begin
          state   <= GAP;
          gap_cnt <= 8'd1;
        end else begin
          state     <= IDLE;
          busy      <= 1'b0;
          din_ready <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (din_valid && din_ready) begin
              sreg      <= advance(din);
              out       <= lead_bit(din);
              out_valid <= 1'b1;
              busy      <= 1'b1;
              din_ready <= 1'b0;
              cnt       <= CW'(1);
              state     <= SHIFT;
`ifdef SER_PARITY_EN
              par       <= ^din;
`endif
            end else begin
              din_ready <= 1'b1;
            end
          end
          SHIFT: begin
`ifdef SER_PARITY_EN
            if (cnt == LAST) begin
              out   <= par;
              done  <= 1'b1;
              state <= PAR;
            end else begin
              out  <= lead_bit(sreg);
              sreg <= advance(sreg);
              cnt  <= cnt + CW'(1);
            end
`else
            out  <= lead_bit(sreg);
            sreg <= advance(sreg);
            cnt  <= cnt + CW'(1);
            done <= (cnt == LAST - CW'(1));
`endif
          end
          GAP: begin
            if (gap_cnt >= GAP_N) begin
              state     <= IDLE;
              busy      <= 1'b0;
              din_ready <= 1'b1;
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moore_bit_serializer.sv
// tb/tb_moore_bit_serializer.sv - bench for moore_bit_serializer, two parameterisations on shared inputs
// Reference model tracks cycles since each accepted word; SER_PARITY_EN is honoured if defined.
module tb_moore_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       rdy0, out0, ov0, busy0, done0;
  logic       rdy1, out1, ov1, busy1, done1;

  always #5 clk = ~clk;

  moore_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .out(out0), .out_valid(ov0), .busy(busy0), .done(done0)
  );

  moore_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .out(out1), .out_valid(ov1), .busy(busy1), .done(done1)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         ph [2] = '{0, 0};
  logic [7:0] word [2] = '{8'h00, 8'h00};
  bit         rdy_m [2] = '{1'b0, 1'b0};
  string      nm [5] = '{"out", "out_valid", "busy", "done", "din_ready"};

  function automatic int msbf(input int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic int gapn(input int i);
    return (i == 0) ? 0 : 2;
  endfunction
  function automatic logic idl(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction
  function automatic int plen(input int i);
    return W + P + gapn(i);
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d got=%0h want=%0h cycle=%0d", name, i, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i]    = 0;
      rdy_m[i] = 1'b0;
    end
  endtask

  // ph = cycles since the accept edge (0 = sitting in idle)
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        ph[i]    = 0;
        rdy_m[i] = 1'b0;
      end else if (ph[i] == 0) begin
        if (rdy_m[i] && din_valid) begin
          word[i] = din;
          ph[i]   = 1;
        end else begin
          rdy_m[i] = 1'b1;
        end
      end else if (ph[i] == plen(i)) begin
        ph[i]    = 0;
        rdy_m[i] = 1'b1;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
  end

  function automatic logic [4:0] expect_outs(input int i);
    int   k;
    logic b;
    k = ph[i];
    if (k == 0) return {idl(i), 1'b0, 1'b0, 1'b0, rdy_m[i]};
    if (k <= W) begin
      b = (msbf(i) != 0) ? word[i][W-k] : word[i][k-1];
      return {b, 1'b1, 1'b1, ((P == 0) && (k == W)), 1'b0};
    end
    if (k <= W + P) return {^word[i], 1'b1, 1'b1, 1'b1, 1'b0};
    return {idl(i), 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] a;
      logic [4:0] e;
      a = (i == 0) ? {out0, ov0, busy0, done0, rdy0} : {out1, ov1, busy1, done1, rdy1};
      e = expect_outs(i);
      for (int f = 0; f < 5; f++) check(nm[f], i, 32'(a[4-f]), 32'(e[4-f]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  lit;
    logic [15:0] cap;
    int          nacc, t1, t2, bi, nbits, ones;
    logic        prev;

    #3 rst = 1'b0;
    model_reset();
    step();
    step();
    check("rst_out", 0, 32'(out0), 0);
    check("rst_out", 1, 32'(out1), 1);
    check("rst_ready", 0, 32'(rdy0), 0);
    check("rst_ready", 1, 32'(rdy1), 0);
    check("rst_busy", 0, 32'(busy0), 0);
    rst = 1'b1;
    step();
    check("ready_after_release", 0, 32'(rdy0), 1);
    check("ready_after_release", 1, 32'(rdy1), 1);

    din = 8'hB4;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    lit = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      check("t1_msb_bit", 0, 32'(out0), 32'(lit[7-k]));
      check("t1_lsb_bit", 1, 32'(out1), 32'(lit[k]));
      check("t1_done", 0, 32'(done0), 32'((k == 7) && (P == 0)));
      step();
    end
    repeat (P) step();
    check("t1_idle_out", 0, 32'(out0), 0);
    check("t1_idle_ready", 0, 32'(rdy0), 1);
    check("t1_gap_out", 1, 32'(out1), 1);
    check("t1_gap_valid", 1, 32'(ov1), 0);
    check("t1_gap_busy", 1, 32'(busy1), 1);
    check("t1_gap_ready", 1, 32'(rdy1), 0);
    step();
    step();
    check("t2_ready_after_gap", 1, 32'(rdy1), 1);

    din = 8'hAA;
    din_valid = 1'b1;
    nacc = 0; t1 = 0; t2 = 0; bi = 8; nbits = 0; cap = '0;
    prev = busy1;
    for (int s = 0; s < 40; s++) begin
      step();
      if (busy1 && !prev) begin
        nacc++;
        bi = 0;
        if (nacc == 1) begin
          t1 = cyc;
          din = 8'h55;
        end else if (nacc == 2) begin
          t2 = cyc;
          din_valid = 1'b0;
        end
      end
      if (ov1 && bi < 8) begin
        cap = {out1, cap[15:1]};
        bi++;
        nbits++;
      end
      prev = busy1;
    end
    check("t4_accepts", 1, nacc, 2);
    check("t4_spacing", 1, t2 - t1, 11 + P);
    check("t4_stream", 1, 32'(cap), 32'h55AA);
    check("t4_bits", 1, nbits, 16);

    for (int s = 0; s < 30 && !rdy0; s++) step();
    check("t5_ready_wait", 0, 32'(rdy0), 1);
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    check("t5_third_bit", 0, 32'(out0), 1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("t5_async_out", 0, 32'(out0), 0);
    check("t5_async_valid", 0, 32'(ov0), 0);
    check("t5_async_busy", 0, 32'(busy0), 0);
    check("t5_async_out", 1, 32'(out1), 1);
    step();
    rst = 1'b1;
    step();
    check("t5_ready_first_edge", 0, 32'(rdy0), 1);
    ones = 0;
    for (int s = 0; s < 12; s++) begin
      step();
      if (out0) ones++;
    end
    check("t5_no_residual", 0, ones, 0);

    repeat (4000) begin
      step();
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
